dds_profile_sched: RTL and testbench
====================================

// Module: dds_profile_sched
// PURPOSE
//  Profile sequencer for the DDS radar-wave generator. Holds a small table of waveform
//  profiles (wave_sel, mode_sel, F, T, Z, dwell) and steps through them, driving the dds
//  parameter inputs. dac_mute stays high while parameters settle through the dds change
//  detector. Sits between the host/config interface and dds; dds output is gated by dac_mute.
// PARAMETERS
//  NUM_PROF    8    number of profile entries (power of 2, >=2)
//  DWELL_W     16   width of per-entry dwell count
//  PRESC       100  sys_clk cycles per dwell tick (>=1)
//  SETTLE_CYC  4    mute cycles after each parameter update (>=1)
// PORTS
//  sys_clk     in   1         system clock
//  sys_rst     in   1         asynchronous reset, active-high
//  start       in   1         1-cycle pulse: begin sequence at entry 0 (honoured in IDLE only)
//  stop        in   1         1-cycle pulse: abort to IDLE from any state
//  loop_en     in   1         1: wrap to entry 0 after the last entry; 0: one-shot
//  wr_en       in   1         table write strobe
//  wr_addr     in   log2(N)   table write index
//  wr_data     in   37+DWELL_W  {dwell,Z[6:0],T[10:0],F[8:0],mode_sel[3:0],wave_sel[5:0]}
//  wr_err      out  1         1-cycle pulse: write rejected (sequencer not IDLE)
//  wave_sel    out  6         to dds
//  mode_sel    out  4         to dds
//  F           out  9         to dds, 1 LSB = 0.1 MHz
//  T           out  11        to dds, pulse time
//  Z           out  7         to dds, duty divisor
//  dac_mute    out  1         1: downstream forces DAC code to mid-scale
//  prof_idx    out  log2(N)   index of the active entry
//  busy        out  1         high in any state other than IDLE
//  done        out  1         1-cycle pulse: one-shot sequence finished or list empty
// BEHAVIOUR
//  Reset: all outputs 0 except dac_mute=1; FSM=IDLE, counters 0; table contents undefined.
//  States: IDLE -> LOAD -> SETTLE -> DWELL -> NEXT -> LOAD ...
//  - IDLE: dac_mute=1, parameter outputs hold last values. start -> LOAD with prof_idx=0.
//  - LOAD (1 cycle): read table[prof_idx]. dwell==0 marks end of list:
//      prof_idx==0 -> done pulse, IDLE (empty list);
//      else loop_en ? (prof_idx<=0, stay LOAD) : (done pulse, IDLE).
//    dwell!=0 -> register all 5 parameter fields to outputs and load settle_cnt=SETTLE_CYC-1.
//    Next state SETTLE.
//  - SETTLE: dac_mute=1; settle_cnt counts down; at 0 -> DWELL, load dwell_cnt=dwell, presc=0.
//  - DWELL: dac_mute=0. presc counts 0..PRESC-1; each wrap decrements dwell_cnt. The wrap that
//    takes dwell_cnt to 0 -> NEXT. Unmuted time is exactly dwell*PRESC cycles.
//  - NEXT (1 cycle, dac_mute=1): prof_idx==NUM_PROF-1 ?
//      (loop_en ? prof_idx<=0, LOAD : done pulse, IDLE) : (prof_idx+1, LOAD).
//  Latency: start sampled at edge k -> new parameters visible after edge k+2;
//    dac_mute falls after edge k+2+SETTLE_CYC.
//  stop has priority over every other event, including a simultaneous start or dwell expiry.
//    Next state IDLE, dac_mute=1 the same edge, no done pulse, parameters held.
//  start while busy is ignored. loop_en is sampled only in LOAD/NEXT.
//  Writes: accepted only in IDLE (takes effect next cycle). Otherwise the table is unchanged
//    and wr_err pulses the cycle after wr_en.
//  Reset asserted mid-sequence: immediate return to reset values; table is not cleared.
//  All outputs registered; no combinational path from input to output.
// STRUCTURE
//  Shared package dds_pkg: field widths (WAVE_W=6, MODE_W=4, F_W=9, T_W=11, Z_W=7),
//    wr_data field offsets, FSM state encoding.
//  Sub-module dds_prof_ram: NUM_PROF x (37+DWELL_W) register file, 1 write port and
//    1 asynchronous read port. Top holds the FSM, prescaler, and counters.
// TESTING (PRESC=4, SETTLE_CYC=2 for sims)
//  1 write e0={dwell=3,wave=1,mode=1,F=50}, e1.dwell=0; start, loop_en=0 -> F=50 at k+2,
//    dac_mute low for exactly 12 cycles, then done pulse, busy=0.
//  2 e0..e7 all dwell=1, loop_en=1 -> prof_idx 0..7,0,1... F tracks each entry;
//    mute gap = NEXT+LOAD+SETTLE = 4 cycles between dwells.
//  3 e0.dwell=0, start -> done pulse 2 cycles after start; parameters unchanged; dac_mute never low.
//  4 stop on the same cycle as the final presc wrap -> IDLE, no done pulse, dac_mute=1,
//    prof_idx held.
//  5 wr_en while busy -> wr_err pulse; entry readback unchanged. Same write in IDLE ->
//    no wr_err, entry updated.
//  6 sys_rst asserted during DWELL -> outputs 0, dac_mute=1 asynchronously; restart replays
//    the table intact.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared field widths, wr_data layout and sequencer state encoding for the DDS profile sequencer.
package dds_pkg;

    localparam int WAVE_W    = 6;
    localparam int MODE_W    = 4;
    localparam int F_W       = 9;
    localparam int T_W       = 11;
    localparam int Z_W       = 7;

    // wr_data layout, LSB first: wave_sel, mode_sel, F, T, Z, then dwell on top
    localparam int WAVE_LSB  = 0;
    localparam int MODE_LSB  = WAVE_LSB + WAVE_W;
    localparam int F_LSB     = MODE_LSB + MODE_W;
    localparam int T_LSB     = F_LSB + F_W;
    localparam int Z_LSB     = T_LSB + T_W;
    localparam int DWELL_LSB = Z_LSB + Z_W;
    localparam int PARAM_W   = DWELL_LSB;

    typedef struct packed {
        logic [Z_W-1:0]    z;
        logic [T_W-1:0]    t;
        logic [F_W-1:0]    f;
        logic [MODE_W-1:0] mode_sel;
        logic [WAVE_W-1:0] wave_sel;
    } dds_par_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_DWELL  = 3'd3,
        ST_NEXT   = 3'd4
    } state_t;

endpackage

// File: rtl/dds_prof_ram.sv
// Profile table: NUM_PROF entries, one synchronous write port, one asynchronous read port.
// No reset on the storage, so contents survive a sequencer reset.
module dds_prof_ram #(
    parameter  int NUM_PROF = 8,
    parameter  int DATA_W   = 53,
    localparam int IDX_W    = $clog2(NUM_PROF)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [NUM_PROF];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/dds_profile_sched.sv
// Steps through the profile table, driving dds parameters and muting the DAC while they settle.
// Params appear one cycle after LOAD; mute lifts SETTLE_CYC cycles later for dwell*PRESC cycles.
module dds_profile_sched
    import dds_pkg::*;
#(
    parameter  int NUM_PROF   = 8,
    parameter  int DWELL_W    = 16,
    parameter  int PRESC      = 100,
    parameter  int SETTLE_CYC = 4,
    localparam int IDX_W      = $clog2(NUM_PROF),
    localparam int DATA_W     = PARAM_W + DWELL_W
) (
    input  logic              i_sys_clk,
    input  logic              i_sys_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_loop_en,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_err,
    output logic [WAVE_W-1:0] o_wave_sel,
    output logic [MODE_W-1:0] o_mode_sel,
    output logic [F_W-1:0]    o_f,
    output logic [T_W-1:0]    o_t,
    output logic [Z_W-1:0]    o_z,
    output logic              o_dac_mute,
    output logic [IDX_W-1:0]  o_prof_idx,
    output logic              o_busy,
    output logic              o_done
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [PRE_W-1:0] PRESC_LAST  = PRE_W'(PRESC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_PROF - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_prof_idx;
    logic [SET_W-1:0]   r_settle_cnt;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [PRE_W-1:0]   r_presc;
    dds_par_t           r_par;
    logic               r_mute;
    logic               r_busy;
    logic               r_done;
    logic               r_wr_err;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [SET_W-1:0]   w_settle_nxt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [PRE_W-1:0]   w_presc_nxt;
    logic               w_load_par;
    logic               w_done_nxt;
    logic               w_wr_ok;
    logic [DATA_W-1:0]  w_rd_data;
    logic [DWELL_W-1:0] w_rd_dwell;
    dds_par_t           w_rd_par;

    // The table is frozen while a sequence runs so the dwell captured in LOAD stays valid.
    assign w_wr_ok = i_wr_en && (r_state == ST_IDLE);

    dds_prof_ram #(
        .NUM_PROF (NUM_PROF),
        .DATA_W   (DATA_W)
    ) u_ram (
        .i_clk     (i_sys_clk),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_rd_addr (r_prof_idx),
        .o_rd_data (w_rd_data)
    );

    assign w_rd_dwell = w_rd_data[DATA_W-1:PARAM_W];
    assign w_rd_par   = dds_par_t'(w_rd_data[PARAM_W-1:0]);

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_prof_idx;
        w_settle_nxt = r_settle_cnt;
        w_dwell_nxt  = r_dwell_cnt;
        w_presc_nxt  = r_presc;
        w_load_par   = 1'b0;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_LOAD;
                    w_idx_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (w_rd_dwell == '0) begin
                    // A zero dwell terminates the list; entry 0 empty means nothing to play.
                    if ((r_prof_idx != '0) && i_loop_en) begin
                        w_idx_nxt = '0;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_load_par   = 1'b1;
                    w_settle_nxt = SETTLE_LAST;
                    w_dwell_nxt  = w_rd_dwell;
                    w_state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_presc_nxt = '0;
                    w_state_nxt = ST_DWELL;
                end else begin
                    w_settle_nxt = r_settle_cnt - SET_W'(1);
                end
            end
            ST_DWELL: begin
                if (r_presc == PRESC_LAST) begin
                    w_presc_nxt = '0;
                    w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                    if (r_dwell_cnt == DWELL_W'(1)) begin
                        w_state_nxt = ST_NEXT;
                    end
                end else begin
                    w_presc_nxt = r_presc + PRE_W'(1);
                end
            end
            ST_NEXT: begin
                if (r_prof_idx == IDX_LAST) begin
                    if (i_loop_en) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_idx_nxt   = r_prof_idx + IDX_W'(1);
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort wins over everything; index and parameters freeze where they are.
        if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = r_prof_idx;
            w_load_par  = 1'b0;
            w_done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            r_state      <= ST_IDLE;
            r_prof_idx   <= '0;
            r_settle_cnt <= '0;
            r_dwell_cnt  <= '0;
            r_presc      <= '0;
            r_par        <= '0;
            r_mute       <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prof_idx   <= w_idx_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_dwell_cnt  <= w_dwell_nxt;
            r_presc      <= w_presc_nxt;
            if (w_load_par) begin
                r_par <= w_rd_par;
            end
            r_mute       <= (w_state_nxt != ST_DWELL);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= w_done_nxt;
            r_wr_err     <= i_wr_en && (r_state != ST_IDLE);
        end
    end

    assign o_wave_sel = r_par.wave_sel;
    assign o_mode_sel = r_par.mode_sel;
    assign o_f        = r_par.f;
    assign o_t        = r_par.t;
    assign o_z        = r_par.z;
    assign o_dac_mute = r_mute;
    assign o_prof_idx = r_prof_idx;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_wr_err   = r_wr_err;

endmodule

// File: tb/tb_dds_profile_sched.sv
// Bench for dds_profile_sched: a table model expands each run into a per-cycle expected trace.
module tb_dds_profile_sched;

    localparam int NPROF  = 8;
    localparam int DW     = 16;
    localparam int PRESC  = 4;
    localparam int SETTLE = 2;
    localparam int NO_EVT = 1 << 30;
    localparam int AT_WRAP = -2;

    typedef struct packed {
        logic [2:0]  idx;
        logic [36:0] par;
        logic        mute;
        logic        busy;
        logic        done;
        logic        err;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [52:0] wr_data = '0;
    logic        wr_err;
    logic [5:0]  wave;
    logic [3:0]  mode;
    logic [8:0]  f;
    logic [10:0] t;
    logic [6:0]  z;
    logic        mute;
    logic [2:0]  idx;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_err = 0;
    int n_low = 0;

    logic [52:0] m_tbl [NPROF];
    logic [36:0] m_par = '0;
    logic [2:0]  m_idx = '0;
    rec_t        exp_q [$];

    dds_profile_sched #(
        .NUM_PROF   (NPROF),
        .DWELL_W    (DW),
        .PRESC      (PRESC),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .i_sys_clk  (clk),
        .i_sys_rst  (rst),
        .i_start    (start),
        .i_stop     (stop),
        .i_loop_en  (loop_en),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .o_wr_err   (wr_err),
        .o_wave_sel (wave),
        .o_mode_sel (mode),
        .o_f        (f),
        .o_t        (t),
        .o_z        (z),
        .o_dac_mute (mute),
        .o_prof_idx (idx),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input rec_t e);
        chk("prof_idx", 64'(idx), 64'(e.idx));
        chk("params", 64'({z, t, f, mode, wave}), 64'(e.par));
        chk("dac_mute", 64'(mute), 64'(e.mute));
        chk("busy", 64'(busy), 64'(e.busy));
        chk("done", 64'(done), 64'(e.done));
        chk("wr_err", 64'(wr_err), 64'(e.err));
        if (mute == 1'b0) n_low++;
    endtask

    function automatic logic [36:0] rnd_par();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[36:0];
    endfunction

    function automatic logic [52:0] mk(input int dwell, input logic [36:0] par);
        return {16'(dwell), par};
    endfunction

    function automatic void push(input int i, input logic [36:0] p, input bit mu, input bit bz, input bit dn);
        rec_t r;
        r.idx = 3'(i); r.par = p; r.mute = mu; r.busy = bz; r.done = dn; r.err = 1'b0;
        exp_q.push_back(r);
    endfunction

    // Expected outputs after each edge from the start edge on: LOAD, SETTLE x S,
    // DWELL x dwell*PRESC, NEXT per entry; a zero dwell ends or rewinds the list.
    function automatic void build(input bit lp, input int n);
        int i;
        int dw;
        logic [36:0] p;
        exp_q.delete();
        i = 0;
        p = m_par;
        push(0, p, 1, 1, 0);
        while (exp_q.size() < n) begin
            dw = int'(m_tbl[i][52:37]);
            if (dw == 0) begin
                if (i != 0 && lp) begin
                    i = 0;
                    push(i, p, 1, 1, 0);
                    continue;
                end
                push(i, p, 1, 0, 1);
                break;
            end
            p = m_tbl[i][36:0];
            repeat (SETTLE) push(i, p, 1, 1, 0);
            repeat (dw * PRESC) push(i, p, 0, 1, 0);
            push(i, p, 1, 1, 0);
            if (i == NPROF - 1 && !lp) begin
                push(i, p, 1, 0, 1);
                break;
            end
            i = (i + 1) % NPROF;
            push(i, p, 1, 1, 0);
        end
    endfunction

    task automatic write_entry(input int a, input logic [52:0] d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        chk("wr_err_idle", 64'(wr_err), 64'd0);
        m_tbl[a] = d;
    endtask

    task automatic run_seq(input bit lp, input int n, input int stop_in, input int wr_at,
                           input int wa, input logic [52:0] wd);
        rec_t prev;
        rec_t e;
        int c;
        int stop_at;
        build(lp, n);
        stop_at = stop_in;
        if (stop_at == AT_WRAP) begin
            stop_at = NO_EVT;
            for (int i = 1; i < exp_q.size(); i++) begin
                if (exp_q[i].mute && !exp_q[i-1].mute) begin
                    stop_at = i;
                    break;
                end
            end
        end
        if (stop_at >= exp_q.size() && exp_q[exp_q.size()-1].busy) stop_at = exp_q.size() - 1;
        prev.idx = m_idx; prev.par = m_par; prev.mute = 1'b1;
        prev.busy = 1'b0; prev.done = 1'b0; prev.err = 1'b0;
        loop_en = lp;
        c = 0;
        while (c < exp_q.size()) begin
            start = (c == 0);
            stop = (c == stop_at);
            wr_en = (c == wr_at); wr_addr = 3'(wa); wr_data = wd;
            step();
            start = 1'b0; stop = 1'b0; wr_en = 1'b0;
            if (c == stop_at) begin
                e = prev; e.mute = 1'b1; e.busy = 1'b0; e.done = 1'b0;
            end else begin
                e = exp_q[c];
            end
            e.err = (c == wr_at) && prev.busy;
            if (c == wr_at && !prev.busy) m_tbl[wa] = wd;
            cmp(e);
            prev = e;
            if (c == stop_at) break;
            c++;
        end
        m_idx = prev.idx;
        m_par = prev.par;
        repeat (2) begin
            step();
            e = prev; e.mute = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.err = 1'b0;
            cmp(e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [52:0] wd;
        int waited;
        int stp;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mute", 64'(mute), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_params", 64'({z, t, f, mode, wave}), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        step();

        // one-shot single entry: F=50, 12 unmuted cycles, done
        write_entry(0, mk(3, {7'd4, 11'd100, 9'd50, 4'd1, 6'd1}));
        write_entry(1, mk(0, rnd_par()));
        for (int i = 2; i < NPROF; i++) write_entry(i, mk(1, rnd_par()));
        n_low = 0;
        run_seq(0, 200, NO_EVT, NO_EVT, 0, '0);
        chk("mute_low_cycles", 64'(n_low), 64'd12);
        chk("f_after_run", 64'(f), 64'd50);

        // looping over all entries with dwell 1, stopped later
        for (int i = 0; i < NPROF; i++) write_entry(i, mk(1, rnd_par()));
        run_seq(1, 100, 100, NO_EVT, 0, '0);

        // empty list
        write_entry(0, mk(0, rnd_par()));
        n_low = 0;
        run_seq(0, 50, NO_EVT, NO_EVT, 0, '0);
        chk("empty_mute_low", 64'(n_low), 64'd0);

        // stop on the final prescaler wrap
        write_entry(0, mk(2, rnd_par()));
        write_entry(1, mk(0, rnd_par()));
        run_seq(0, 100, AT_WRAP, NO_EVT, 0, '0);

        // write while busy rejected, then accepted in idle
        for (int i = 0; i < NPROF; i++) write_entry(i, mk(1, rnd_par()));
        wd = mk(2, rnd_par());
        run_seq(1, 40, 40, 10, 3, wd);
        run_seq(0, 200, NO_EVT, NO_EVT, 0, '0);
        write_entry(3, wd);
        run_seq(0, 200, NO_EVT, NO_EVT, 0, '0);

        // asynchronous reset during dwell, then replay
        write_entry(0, mk(3, rnd_par()));
        write_entry(1, mk(2, rnd_par()));
        write_entry(2, mk(0, rnd_par()));
        loop_en = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        waited = 0;
        while (mute && waited < 50) begin
            step();
            waited++;
        end
        chk("reached_dwell", 64'(mute), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_mute", 64'(mute), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_idx", 64'(idx), 64'd0);
        chk("arst_params", 64'({z, t, f, mode, wave}), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        #3 rst = 1'b0;
        m_par = '0;
        m_idx = '0;
        run_seq(0, 200, NO_EVT, NO_EVT, 0, '0);

        // randomized tables, loop mode, stop and write timing
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < NPROF; i++)
                write_entry(i, mk(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3)), rnd_par()));
            stp = ($urandom_range(0, 2) == 0) ? NO_EVT : int'($urandom_range(0, 140));
            run_seq(1'($urandom_range(0, 1)), 150, stp, int'($urandom_range(1, 60)),
                    int'($urandom_range(0, NPROF - 1)), mk(int'($urandom_range(1, 3)), rnd_par()));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
